kv_table: RTL
=============

Name: kv_table

Overview:
- Downstream consumer of the byte-to-key/value assembler.
- Accepts assembled 32-bit keys with 64-bit values and an opcode.
- Stores up to DEPTH entries; performs lookup, insert/update and delete by sequential search, one entry per clock.
- Returns a status and value to the next stage over a valid/ready response channel.

Parameters:
DEPTH, 8, number of table entries (power of 2, 2..64)
KEY_W, 32, key width in bits
VAL_W, 64, value width in bits

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept request
req_op  in  2  0=LOOKUP, 1=INSERT, 2=DELETE, 3=reserved
req_key  in  KEY_W  request key
req_val  in  VAL_W  value for INSERT, ignored otherwise
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_status  out  2  0=HIT/OK, 1=MISS, 2=FULL, 3=BADOP
rsp_val  out  VAL_W  stored value on LOOKUP hit, else 0
count  out  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous, active-low.
- Reset values: valid bits all 0; count=0; req_ready=0 during reset and 1 the cycle after; rsp_valid=0, rsp_status=0, rsp_val=0; FSM=IDLE.
- Reset mid-search or mid-response aborts the operation. No table change is committed.
- FSM states: IDLE, SEARCH, RESP.
  - IDLE: req_ready=1. On req_valid&req_ready, latch op/key/val, set idx=0, hit=0, free_found=0 -> SEARCH.
  - SEARCH: req_ready=0. Each cycle examine entry idx:
    - If valid and key equal: record hit and hit index. The first match wins; only one can exist.
    - If not valid and !free_found: record free index.
    - idx increments; after idx=DEPTH-1 -> RESP. The search never terminates early.
  - RESP: rsp_valid=1, outputs stable until rsp_ready. On rsp_valid&rsp_ready -> IDLE.
- Commit of table updates happens on the SEARCH->RESP transition edge:
  - LOOKUP hit: status 0, rsp_val=entry value. Miss: status 1, rsp_val=0.
  - INSERT hit: overwrite value, status 0. Miss with free slot: write key/value at lowest free index, set valid, count+1, status 0. Miss with no free slot: status 2 (FULL), no change.
  - DELETE hit: clear valid, count-1, status 0. Miss: status 1.
  - op 3: full search still runs, status 3, no change.
- Latency: request accepted at cycle T; rsp_valid first high at T+DEPTH+1. Fixed, independent of hit position.
- Throughput: one request in flight. req_ready=0 from acceptance until the response handshake completes.
- req_ready is 1 in the cycle after the rsp handshake; no combinational path from rsp_ready to req_ready.
- Requests held by the producer while req_ready=0 are not lost and not sampled.
- count never exceeds DEPTH and never underflows.
- Only valid entries are compared; stale keys in invalid slots never produce a hit.

Optional Feature:
- Macro: KV_STATS_EN.
- When defined, adds outputs hit_cnt[15:0] and miss_cnt[15:0].
  - hit_cnt increments on each LOOKUP response with status 0.
  - miss_cnt increments on each LOOKUP response with status 1.
  - Counting occurs at the rsp handshake. Both counters saturate at 16'hFFFF and reset to 0.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then LOOKUP key 32'hDEADBEEF -> rsp_status=1, rsp_val=0, count=0, rsp_valid at exactly DEPTH+1 cycles after acceptance (9 for DEPTH=8).
- INSERT key 32'h00000001 val 64'h1122334455667788, then LOOKUP same key -> both status 0, rsp_val=64'h1122334455667788, count=1.
- INSERT 8 distinct keys 1..8, then INSERT key 9 -> status 2, count=8. Then INSERT key 3 val 64'hAA -> status 0 (update), count still 8.
- Fill with keys 1..8, DELETE key 5, INSERT key 42 -> status 0, stored at index 4. LOOKUP 5 -> status 1. LOOKUP 42 -> status 0.
- Hold rsp_ready=0 for 20 cycles with a new req_valid asserted -> rsp outputs stable, req_ready=0, second request accepted only on the cycle after the rsp handshake.
- Assert rst_n=0 mid-SEARCH of an INSERT to an empty table -> count=0, rsp_valid=0, and a subsequent LOOKUP of that key returns status 1. With KV_STATS_EN: 3 hit and 2 miss lookups -> hit_cnt=3, miss_cnt=2.

Source files
------------

// File: rtl/kv_table.sv
// kv_table: DEPTH-entry key/value store, sequential search one entry per clock, fixed DEPTH+1 cycle latency.
// One request in flight; req_ready stays low until the response handshake. `define KV_STATS_EN adds lookup hit/miss counters.
module kv_table #(
  parameter int DEPTH = 8,
  parameter int KEY_W = 32,
  parameter int VAL_W = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [KEY_W-1:0]       req_key,
  input  logic [VAL_W-1:0]       req_val,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [1:0]             rsp_status,
  output logic [VAL_W-1:0]       rsp_val,
  output logic [$clog2(DEPTH):0] count
`ifdef KV_STATS_EN
  ,
  output logic [15:0]            hit_cnt,
  output logic [15:0]            miss_cnt
`endif
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam logic [1:0] IDLE = 2'd0, SEARCH = 2'd1, RESP = 2'd2;
  localparam logic [1:0] OP_LOOKUP = 2'd0, OP_INSERT = 2'd1, OP_DELETE = 2'd2;
  localparam logic [1:0] ST_OK = 2'd0, ST_MISS = 2'd1, ST_FULL = 2'd2, ST_BADOP = 2'd3;

  logic [1:0]       state;
  logic [KEY_W-1:0] keys [DEPTH];
  logic [VAL_W-1:0] vals [DEPTH];
  logic [DEPTH-1:0] vld;

  logic [1:0]       cur_op;
  logic [KEY_W-1:0] cur_key;
  logic [VAL_W-1:0] cur_val;
  logic [IW-1:0]    idx, hit_idx, free_idx;
  logic             hit, free_found;

  logic             accept, last, commit, match, empty, hit_n, free_n;
  logic [IW-1:0]    hit_idx_n, free_idx_n, wr_idx;
  logic             wr_val, wr_key;

  // Search state folded with the entry under examination, so the final cycle commits with full knowledge.
  always_comb begin
    accept     = (state == IDLE) && req_valid && req_ready;
    last       = (idx == IW'(DEPTH - 1));
    commit     = (state == SEARCH) && last;
    match      = vld[idx] && (keys[idx] == cur_key);
    empty      = !vld[idx];
    hit_n      = hit | match;
    hit_idx_n  = (match && !hit) ? idx : hit_idx;
    free_n     = free_found | empty;
    free_idx_n = (empty && !free_found) ? idx : free_idx;
    wr_val     = commit && (cur_op == OP_INSERT) && (hit_n || free_n);
    wr_key     = commit && (cur_op == OP_INSERT) && !hit_n && free_n;
    wr_idx     = hit_n ? hit_idx_n : free_idx_n;
  end

  assign rsp_valid = (state == RESP);

  // Payload storage carries no reset; only the valid bits define table contents.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (wr_val) vals[wr_idx] <= cur_val;
      if (wr_key) keys[wr_idx] <= cur_key;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      vld        <= '0;
      count      <= '0;
      rsp_status <= ST_OK;
      rsp_val    <= '0;
      cur_op     <= OP_LOOKUP;
      cur_key    <= '0;
      cur_val    <= '0;
      idx        <= '0;
      hit_idx    <= '0;
      free_idx   <= '0;
      hit        <= 1'b0;
      free_found <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready  <= 1'b0;
            cur_op     <= req_op;
            cur_key    <= req_key;
            cur_val    <= req_val;
            idx        <= '0;
            hit        <= 1'b0;
            free_found <= 1'b0;
            state      <= SEARCH;
          end
        end
        SEARCH: begin
          hit        <= hit_n;
          hit_idx    <= hit_idx_n;
          free_found <= free_n;
          free_idx   <= free_idx_n;
          idx        <= idx + IW'(1);
          if (last) begin
            state   <= RESP;
            rsp_val <= '0;
            case (cur_op)
              OP_LOOKUP: begin
                rsp_status <= hit_n ? ST_OK : ST_MISS;
                if (hit_n) rsp_val <= vals[hit_idx_n];
              end
              OP_INSERT: begin
                if (hit_n) begin
                  rsp_status <= ST_OK;
                end else if (free_n) begin
                  rsp_status       <= ST_OK;
                  vld[free_idx_n]  <= 1'b1;
                  count            <= count + CW'(1);
                end else begin
                  rsp_status <= ST_FULL;
                end
              end
              OP_DELETE: begin
                if (hit_n) begin
                  rsp_status     <= ST_OK;
                  vld[hit_idx_n] <= 1'b0;
                  count          <= count - CW'(1);
                end else begin
                  rsp_status <= ST_MISS;
                end
              end
              default: rsp_status <= ST_BADOP;
            endcase
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KV_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (rsp_valid && rsp_ready && (cur_op == OP_LOOKUP)) begin
      if (rsp_status == ST_OK && hit_cnt != 16'hFFFF)    hit_cnt  <= hit_cnt + 16'd1;
      if (rsp_status == ST_MISS && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
    end
  end
`endif

endmodule
